// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Turns one 32-bit CPU load/store into two 16-bit SRAM phases,
//               holding the pipeline frozen until the access is complete.
// Revision    : 1.0  initial release
// ============================================================================
module sram_controller #(
  parameter int unsigned WAIT = 3,
  parameter logic [31:0] BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [3:0] c_last_cnt = 4'(WAIT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [15:0] r_wdata_hi;
  logic        w_phase_end;
  logic [18:0] w_off;
  logic        w_unused;

  // Only offset bits [18:2] select the SRAM word; the rest wrap away.
  assign w_off       = {addr[18:2], 2'b00} - BASE[18:0];
  assign w_unused    = &{1'b0, addr[31:19], addr[1:0], w_off[1:0]};
  assign w_phase_end = (r_cnt == c_last_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (wr_en) begin
          w_next = WR_LO;
        end else if (rd_en) begin
          w_next = RD_LO;
        end else begin
          ready = 1'b1;
        end
      end
      RD_LO: if (w_phase_end) w_next = RD_HI;
      RD_HI: if (w_phase_end) w_next = DONE;
      WR_LO: if (w_phase_end) w_next = WR_HI;
      WR_HI: if (w_phase_end) w_next = DONE;
      DONE: begin
        w_next = IDLE;
        ready  = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter restarts at every phase entry so each phase spans WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if ((r_state == IDLE) || (w_next != r_state)) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata       <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      r_wdata_hi  <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_en || rd_en) begin
            sram_addr <= {w_off[18:2], 1'b0};
          end
          if (wr_en) begin
            sram_dq_out <= wdata[15:0];
            r_wdata_hi  <= wdata[31:16];
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= 1'b0;
          end
        end
        RD_LO: begin
          if (w_phase_end) begin
            rdata[15:0]  <= sram_dq_in;
            sram_addr[0] <= 1'b1;
          end
        end
        RD_HI: begin
          if (w_phase_end) begin
            rdata[31:16] <= sram_dq_in;
          end
        end
        WR_LO: begin
          if (w_phase_end) begin
            sram_addr[0] <= 1'b1;
            sram_dq_out  <= r_wdata_hi;
          end
        end
        WR_HI: begin
          if (w_phase_end) begin
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Randomised scoreboard bench for sram_controller with an SRAM
//               model, a word-level reference memory and a WAIT sweep.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sram_controller;

  localparam int          W    = 3;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int          MSZ  = 262144;

  typedef struct {
    int          done_cyc;
    logic [31:0] rdata;
  } done_t;

  typedef struct {
    bit          chk_addr;
    bit          chk_rdy;
    logic        rdy;
    logic [17:0] a;
    logic        we_n;
    logic        oe;
    logic [15:0] dq;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in, sram_dq_out;
  logic        sram_dq_oe, sram_we_n;

  logic        s_wr, s_rd;
  logic [31:0] s_addr, s_wdata;
  logic [15:0] s_dq_in;
  logic [31:0] rdata1, rdata15;
  logic        ready1, ready15;
  logic [17:0] saddr1, saddr15;
  logic [15:0] dq1, dq15;
  logic        oe1, oe15, we1, we15;

  logic [15:0] sram    [MSZ];
  logic [15:0] ref_mem [MSZ];
  logic [31:0] ref_rdata;

  done_t exp_q [$];
  bus_t  bus_exp [int];
  int    sw_q1 [$];
  int    sw_q15 [$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit mon_skip = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller #(.WAIT(W), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_in(sram_dq_in),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.WAIT(1), .BASE(BASE)) dut_w1 (
    .clk(clk), .rst(rst), .rd_en(s_rd), .wr_en(s_wr), .addr(s_addr), .wdata(s_wdata),
    .rdata(rdata1), .ready(ready1), .sram_addr(saddr1), .sram_dq_in(s_dq_in),
    .sram_dq_out(dq1), .sram_dq_oe(oe1), .sram_we_n(we1)
  );

  sram_controller #(.WAIT(15), .BASE(BASE)) dut_w15 (
    .clk(clk), .rst(rst), .rd_en(s_rd), .wr_en(s_wr), .addr(s_addr), .wdata(s_wdata),
    .rdata(rdata15), .ready(ready15), .sram_addr(saddr15), .sram_dq_in(s_dq_in),
    .sram_dq_out(dq15), .sram_dq_oe(oe15), .sram_we_n(we15)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503) ^ 16'h5A3C;
  endfunction

  // SRAM word index of the low half, straight from the address map rule.
  function automatic int unsigned lo_idx(input logic [31:0] a);
    logic [31:0] off;
    off = (a & 32'hFFFF_FFFC) - BASE;
    return ((off / 4) % 131072) * 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asynchronous SRAM model: combinational read, write on every strobed cycle.
  assign sram_dq_in = sram[sram_addr];
  initial begin : sram_model
    for (int i = 0; i < MSZ; i++) sram[i] = init_val(i);
    sram[2] = 16'h5678;
    sram[3] = 16'h1234;
    forever begin
      @(posedge clk);
      if (!sram_we_n) sram[sram_addr] <= sram_dq_out;
    end
  end

  initial begin : monitor
    logic prev;
    bus_t b;
    done_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (bus_exp.exists(cyc)) begin
        b = bus_exp[cyc];
        bus_exp.delete(cyc);
      end else begin
        b.chk_addr = 0; b.chk_rdy = 0; b.rdy = 1'b1; b.a = '0;
        b.we_n = 1'b1; b.oe = 1'b0; b.dq = '0;
      end
      check("we_n", {31'd0, sram_we_n}, {31'd0, b.we_n});
      check("dq_oe", {31'd0, sram_dq_oe}, {31'd0, b.oe});
      if (b.chk_rdy) check("ready", {31'd0, ready}, {31'd0, b.rdy});
      if (b.chk_addr) check("sram_addr", {14'd0, sram_addr}, {14'd0, b.a});
      if (b.oe) check("dq_out", {16'd0, sram_dq_out}, {16'd0, b.dq});
      if (!mon_skip && ready && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ready_pulse: got unexpected completion expected none (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("rdata", rdata, e.rdata);
        end
      end
      prev = ready;
    end
  end

  initial begin : monitor_sweep
    logic p1, p15;
    p1 = 1'b1;
    p15 = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && ready1 && !p1 && sw_q1.size() != 0) check("w1_done", cyc, sw_q1.pop_front());
      if (!rst && ready15 && !p15 && sw_q15.size() != 0) check("w15_done", cyc, sw_q15.pop_front());
      p1 = ready1;
      p15 = ready15;
    end
  end

  task automatic do_access(input bit is_wr, input bit also_rd, input logic [31:0] a,
                           input logic [31:0] d);
    int s;
    int unsigned lo;
    bus_t b;
    done_t e;
    s = cyc;
    lo = lo_idx(a);
    wr_en = is_wr;
    rd_en = !is_wr || also_rd;
    addr = a;
    wdata = d;
    if (is_wr) begin
      ref_mem[lo] = d[15:0];
      ref_mem[lo + 1] = d[31:16];
    end else begin
      ref_rdata = {ref_mem[lo + 1], ref_mem[lo]};
    end
    e.done_cyc = s + 2 * W + 1;
    e.rdata = ref_rdata;
    exp_q.push_back(e);
    b.chk_addr = 0; b.chk_rdy = 1; b.rdy = 1'b0; b.a = '0;
    b.we_n = 1'b1; b.oe = 1'b0; b.dq = '0;
    bus_exp[s] = b;
    for (int i = 1; i <= 2 * W; i++) begin
      b.chk_addr = 1;
      b.a = 18'(lo + ((i > W) ? 1 : 0));
      b.we_n = !is_wr;
      b.oe = is_wr;
      b.dq = (i > W) ? d[31:16] : d[15:0];
      bus_exp[s + i] = b;
    end
    b.chk_addr = 0; b.rdy = 1'b1; b.we_n = 1'b1; b.oe = 1'b0;
    bus_exp[s + 2 * W + 1] = b;
    // Inputs are scrambled mid-access; the latched request must win.
    for (int i = 1; i <= 2 * W + 1; i++) begin
      @(posedge clk); #1;
      rd_en = 1'($urandom);
      wr_en = 1'($urandom);
      addr = $urandom;
      wdata = $urandom;
    end
  endtask

  task automatic next_slot(input int gap);
    @(posedge clk); #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 16);
    if (k == 16) k = -1;
    return BASE + 32'(4 * k) + ($urandom_range(0, 8191) << 19) + $urandom_range(0, 3);
  endfunction

  initial begin : stimulus
    int s;
    int unsigned lo;
    logic [31:0] d;
    int kind;
    int idx_list [$];

    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
    s_wr = 1'b0; s_rd = 1'b0; s_addr = '0; s_wdata = '0; s_dq_in = '0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_val(i);
    ref_mem[2] = 16'h5678;
    ref_mem[3] = 16'h1234;
    ref_rdata = 32'd0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rdata", rdata, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    check("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    mon_skip = 1'b0;

    do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    next_slot(1);
    do_access(1'b0, 1'b0, 32'd1028, 32'h0);
    next_slot(0);
    do_access(1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D);
    next_slot(2);
    do_access(1'b1, 1'b0, 32'd1020, 32'h0BAD_1DEA);
    next_slot(0);
    do_access(1'b0, 1'b0, 32'd1020, 32'h0);

    for (int n = 0; n < 150; n++) begin
      next_slot(($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      kind = $urandom_range(0, 3);
      do_access(kind >= 2, kind == 3, rand_addr(), $urandom);
    end

    // Abort a write just before its HI phase begins.
    next_slot(0);
    do_access(1'b0, 1'b0, 32'd1028, 32'h0);
    next_slot(1);
    s = cyc;
    d = $urandom;
    lo = lo_idx(BASE + 32'd8);
    wr_en = 1'b1; addr = BASE + 32'd8; wdata = d;
    ref_mem[lo] = d[15:0];
    for (int i = 1; i <= W; i++) begin
      bus_exp[s + i].chk_addr = 1; bus_exp[s + i].chk_rdy = 1; bus_exp[s + i].rdy = 1'b0;
      bus_exp[s + i].a = 18'(lo); bus_exp[s + i].we_n = 1'b0; bus_exp[s + i].oe = 1'b1;
      bus_exp[s + i].dq = d[15:0];
    end
    repeat (W) begin
      @(posedge clk); #1;
    end
    #6;
    mon_skip = 1'b1;
    rst = 1'b1;
    wr_en = 1'b0;
    ref_rdata = 32'd0;
    @(posedge clk); #1;
    check("abort_we_n", {31'd0, sram_we_n}, 32'd1);
    check("abort_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_rdata", rdata, 32'd0);
    check("abort_sram_addr", {14'd0, sram_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    mon_skip = 1'b0;

    do_access(1'b0, 1'b0, 32'd1032, 32'h0);
    for (int n = 0; n < 30; n++) begin
      next_slot(($urandom_range(0, 2) == 0) ? 1 : 0);
      kind = $urandom_range(0, 3);
      do_access(kind >= 2, kind == 3, rand_addr(), $urandom);
    end
    next_slot(1);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_pending", exp_q.size(), 32'd0);

    for (int i = 0; i < 32; i++) idx_list.push_back(i);
    idx_list.push_back(32'h3FFFE);
    idx_list.push_back(32'h3FFFF);
    foreach (idx_list[j]) check($sformatf("mem[%0h]", idx_list[j]),
                                {16'd0, sram[idx_list[j]]}, {16'd0, ref_mem[idx_list[j]]});

    @(posedge clk); #1;
    s_wr = 1'b1; s_addr = 32'd1024; s_wdata = 32'hDEADBEEF;
    sw_q1.push_back(cyc + 2 * 1 + 1);
    sw_q15.push_back(cyc + 2 * 15 + 1);
    @(posedge clk); #1;
    s_wr = 1'b0;
    for (int i = 0; i < 60 && (sw_q1.size() != 0 || sw_q15.size() != 0); i++) @(posedge clk);
    check("sweep_pending", sw_q1.size() + sw_q15.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT, default 3, SHALL set the SRAM cycles held per 16-bit half-word phase; legal range 1..15.
REQ-002 Parameter BASE, default 32'd1024, SHALL be the CPU byte address that maps to SRAM word 0.
REQ-003 clk  input  1  SHALL be the system clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 rd_en  input  1  SHALL be the MEM-stage read request.
REQ-006 wr_en  input  1  SHALL be the MEM-stage write request.
REQ-007 addr  input  32  SHALL be the CPU byte address, word aligned.
REQ-008 wdata  input  32  SHALL be the CPU store data.
REQ-009 rdata  output  32  SHALL be the CPU load data, registered.
REQ-010 ready  output  1  SHALL be low when the pipeline must freeze, and high otherwise.
REQ-011 sram_addr  output  18  SHALL be the SRAM half-word address, registered.
REQ-012 sram_dq_in  input  16  SHALL be the SRAM data bus, read side.
REQ-013 sram_dq_out  output  16  SHALL be the SRAM data bus, write side, registered.
REQ-014 sram_dq_oe  output  1  SHALL enable the bus drive and be high only in write phases.
REQ-015 sram_we_n  output  1  SHALL be the SRAM write strobe, active-low.

Function
REQ-016 The block SHALL implement the FSM states IDLE, RD_LO, RD_HI, WR_LO, WR_HI and DONE.
REQ-017 In IDLE, wr_en=1 SHALL cause a transition to WR_LO, rd_en=1 alone to RD_LO, and neither SHALL keep the FSM in IDLE; wr_en has priority when both are high.
REQ-018 ready SHALL be combinational: 1 in DONE, 1 in IDLE when rd_en=wr_en=0, and 0 in every other case, including IDLE with a request pending.
REQ-019 A 4-bit counter SHALL clear on each phase entry; each LO/HI phase SHALL last exactly WAIT cycles before advancing LO->HI->DONE.
REQ-020 DONE SHALL last exactly one cycle and then return to IDLE; a request present in the following IDLE cycle SHALL start a new access.
REQ-021 Latency: a request first seen in IDLE at cycle 0 SHALL hold ready=0 for cycles 0..2*WAIT and SHALL give ready=1 at cycle 2*WAIT+1 (cycle 7 for WAIT=3).
REQ-022 Address mapping SHALL be off=(addr-BASE) mod 2^32, with sram_addr={off[18:2],0} in LO phases and {off[18:2],1} in HI phases.
REQ-023 Address bits above bit 18 SHALL be ignored (wrap-around), and addr[1:0] SHALL be ignored.
REQ-024 During RD_LO the block SHALL capture sram_dq_in into rdata[15:0] on the last cycle of the phase.
REQ-025 During RD_HI the block SHALL capture sram_dq_in into rdata[31:16] on the last cycle of the phase.
REQ-026 rdata SHALL hold its value until the next read completes; writes SHALL NOT alter rdata.
REQ-027 In WR_LO, sram_dq_out SHALL be wdata[15:0]; in WR_HI, wdata[31:16]; sram_dq_oe=1 and sram_we_n=0 SHALL hold for every cycle of both phases.
REQ-028 wdata and addr SHALL be latched at IDLE exit; input changes during an access SHALL have no effect.
REQ-029 Outside write phases the block SHALL drive sram_we_n=1 and sram_dq_oe=0, and sram_dq_out SHALL keep its last value.
REQ-030 rd_en or wr_en deasserted mid-access SHALL NOT abort the access; it SHALL complete through DONE.

Reset
REQ-031 rst=1 SHALL immediately force: state IDLE, counter 0, rdata 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1.
REQ-032 Reset asserted mid-access SHALL abort the access with no further SRAM strobes and SHALL leave rdata at 0.
REQ-033 After rst deasserts, the first request SHALL follow the REQ-021 timing.

Verification
REQ-034 Write test (WAIT=3): addr=1024, wdata=32'hDEADBEEF, wr_en=1 -> cycles 1-3 sram_addr=0, dq_out=16'hBEEF, we_n=0; cycles 4-6 sram_addr=1, dq_out=16'hDEAD; ready=1 at cycle 7.
REQ-035 Read test: SRAM model pre-loaded [2]=16'h5678, [3]=16'h1234; rd_en=1, addr=1028 -> rdata=32'h12345678 with ready=1 at cycle 7; we_n=1 and dq_oe=0 throughout.
REQ-036 Simultaneous request: rd_en=wr_en=1 -> WR_LO path taken, we_n toggles, rdata unchanged.
REQ-037 Back-to-back: rd_en held high across DONE -> second access starts in the following IDLE cycle, and ready pulses high exactly once per access.
REQ-038 Reset mid-access: rst=1 at cycle 4 of a write -> we_n=1, dq_oe=0 and ready=1 (no request pending) immediately, with no HI-phase strobe.
REQ-039 Wrap and WAIT sweep: addr=1020 maps to sram_addr 18'h3FFFE/3FFFF; repeat REQ-034 with WAIT=1 and WAIT=15 -> ready at cycles 3 and 31.
